pg_pulse_meas: RTL and testbench

Pulse measurement block for the pulse-generator fabric: it samples an asynchronous external signal and measures one pulse's high width and rise-to-rise period in clock cycles. It is the receive-side counterpart of the one-shot generator, used to loop back and check generated pulses or to characterise external sources. A measurement is armed by a single-cycle command, and results are held with a valid flag until the next arm.

---
 rtl/pg_pulse_meas.sv | 131 +++++++++++++
 tb/tb_pg_pulse_meas.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pg_pulse_meas.sv
// Measures one pulse's synchronised high width and rise-to-rise period in i_clk cycles, from an arm command.
// Results appear on the clock edge that sees the terminating edge and stay held until the next arm; there is no backpressure.
module pg_pulse_meas #(
  parameter int CNT_W       = 24,
  parameter int SYNC_STAGES = 2
) (
  input  logic             i_clk,
  input  logic             i_res_n,
  input  logic             i_sig,
  input  logic             i_arm,
  output logic             o_busy,
  output logic             o_valid,
  output logic [CNT_W-1:0] o_width,
  output logic [CNT_W-1:0] o_period,
  output logic             o_ovf
);

  localparam int MASK_N = SYNC_STAGES + 1;
  localparam int MASK_W = $clog2(MASK_N + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_RISE,
    HIGH,
    LOW,
    DONE
  } state_t;

  state_t                  state;
  logic [SYNC_STAGES-1:0]  sync_q;
  logic                    s_d;
  logic [MASK_W-1:0]       mask_cnt;
  logic [CNT_W-1:0]        cnt;

  logic s;
  logic edge_en;
  logic rise;
  logic fall;
  logic at_max;
  logic [CNT_W-1:0] cnt_inc;

  assign s       = sync_q[SYNC_STAGES-1];
  assign edge_en = (mask_cnt == MASK_W'(MASK_N));
  assign rise    = edge_en & s & ~s_d;
  assign fall    = edge_en & ~s & s_d;
  assign at_max  = (cnt == CNT_MAX);
  // Saturating increment: the overflow rule, not wrap-around, ends a long measurement.
  assign cnt_inc = at_max ? cnt : cnt + CNT_W'(1);

  always_ff @(posedge i_clk or negedge i_res_n) begin
    if (!i_res_n) begin
      sync_q   <= '0;
      s_d      <= 1'b0;
      mask_cnt <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], i_sig};
      s_d    <= s;
      // Keeps a level that is already high at reset from looking like a rise.
      if (!edge_en)
        mask_cnt <= mask_cnt + MASK_W'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_res_n) begin
    if (!i_res_n) begin
      state    <= IDLE;
      cnt      <= '0;
      o_busy   <= 1'b0;
      o_valid  <= 1'b0;
      o_width  <= '0;
      o_period <= '0;
      o_ovf    <= 1'b0;
    end else if (i_arm) begin
      state    <= WAIT_RISE;
      cnt      <= '0;
      o_busy   <= 1'b1;
      o_valid  <= 1'b0;
      o_width  <= '0;
      o_period <= '0;
      o_ovf    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
        end
        WAIT_RISE: begin
          if (rise) begin
            cnt   <= CNT_W'(1);
            state <= HIGH;
          end
        end
        HIGH: begin
          if (fall) begin
            o_width <= cnt;
            cnt     <= cnt_inc;
            state   <= LOW;
          end else if (at_max && !rise) begin
            o_width  <= CNT_MAX;
            o_period <= CNT_MAX;
            o_ovf    <= 1'b1;
            o_busy   <= 1'b0;
            o_valid  <= 1'b1;
            state    <= DONE;
          end else begin
            cnt <= cnt_inc;
          end
        end
        LOW: begin
          if (rise) begin
            o_period <= cnt;
            o_busy   <= 1'b0;
            o_valid  <= 1'b1;
            state    <= DONE;
          end else if (at_max && !fall) begin
            o_period <= CNT_MAX;
            o_ovf    <= 1'b1;
            o_busy   <= 1'b0;
            o_valid  <= 1'b1;
            state    <= DONE;
          end else begin
            cnt <= cnt_inc;
          end
        end
        DONE: begin
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pg_pulse_meas.sv
// Scoreboard bench: one 24-bit and one 4-bit measurement unit share a signal and reset, each with its own arm.
module tb_pg_pulse_meas;

  logic        clk;
  logic        res_n;
  logic        sig;
  logic        arm24;
  logic        arm4;

  logic        busy24, valid24, ovf24;
  logic [23:0] width24, period24;
  logic        busy4, valid4, ovf4;
  logic [3:0]  width4, period4;

  typedef struct packed {
    logic [23:0] w;
    logic [23:0] p;
    logic        ovf;
  } exp_t;

  exp_t q24[$];
  exp_t q4[$];

  int n_tests = 0;
  int n_fail  = 0;

  pg_pulse_meas #(.CNT_W(24), .SYNC_STAGES(2)) dut24 (
    .i_clk(clk), .i_res_n(res_n), .i_sig(sig), .i_arm(arm24),
    .o_busy(busy24), .o_valid(valid24), .o_width(width24),
    .o_period(period24), .o_ovf(ovf24)
  );

  pg_pulse_meas #(.CNT_W(4), .SYNC_STAGES(2)) dut4 (
    .i_clk(clk), .i_res_n(res_n), .i_sig(sig), .i_arm(arm4),
    .o_busy(busy4), .o_valid(valid4), .o_width(width4),
    .o_period(period4), .o_ovf(ovf4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse(input int hi, input int lo);
    sig = 1'b1;
    tick(hi);
    sig = 1'b0;
    tick(lo);
  endtask

  task automatic do_arm24(input string name);
    arm24 = 1'b1;
    tick();
    arm24 = 1'b0;
    chk({name, " busy24"}, 32'(busy24), 32'd1);
    chk({name, " valid24"}, 32'(valid24), 32'd0);
    chk({name, " ovf24"}, 32'(ovf24), 32'd0);
  endtask

  task automatic do_arm4(input string name);
    arm4 = 1'b1;
    tick();
    arm4 = 1'b0;
    chk({name, " busy4"}, 32'(busy4), 32'd1);
    chk({name, " valid4"}, 32'(valid4), 32'd0);
  endtask

  task automatic wait_v24(input string name, input int budget);
    int k = 0;
    while (valid24 !== 1'b1 && k < budget) begin
      tick();
      k++;
    end
    chk({name, " result24 arrived"}, 32'(valid24), 32'd1);
    tick(2);
  endtask

  task automatic wait_v4(input string name, input int budget);
    int k = 0;
    while (valid4 !== 1'b1 && k < budget) begin
      tick();
      k++;
    end
    chk({name, " result4 arrived"}, 32'(valid4), 32'd1);
    tick(2);
  endtask

  // Monitors: a result is presented when o_valid rises; compare against the oldest expectation.
  logic pv24 = 1'b0;
  logic pv4  = 1'b0;

  always @(negedge clk) begin
    if (res_n === 1'b1 && valid24 === 1'b1 && pv24 !== 1'b1) begin
      if (q24.size() == 0) begin
        chk("unexpected result24", 32'(valid24), 32'd0);
      end else begin
        exp_t e;
        e = q24.pop_front();
        chk("width24", 32'(width24), 32'(e.w));
        chk("period24", 32'(period24), 32'(e.p));
        chk("ovf24", 32'(ovf24), 32'(e.ovf));
        chk("busy24 at done", 32'(busy24), 32'd0);
      end
    end
    pv24 <= valid24;
  end

  always @(negedge clk) begin
    if (res_n === 1'b1 && valid4 === 1'b1 && pv4 !== 1'b1) begin
      if (q4.size() == 0) begin
        chk("unexpected result4", 32'(valid4), 32'd0);
      end else begin
        exp_t e;
        e = q4.pop_front();
        chk("width4", 32'(width4), 32'(e.w));
        chk("period4", 32'(period4), 32'(e.p));
        chk("ovf4", 32'(ovf4), 32'(e.ovf));
        chk("busy4 at done", 32'(busy4), 32'd0);
      end
    end
    pv4 <= valid4;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    res_n = 1'b1;
    sig   = 1'b0;
    arm24 = 1'b0;
    arm4  = 1'b0;
    #2 res_n = 1'b0;
    tick(3);
    chk("reset busy", 32'(busy24), 32'd0);
    chk("reset valid", 32'(valid24), 32'd0);
    chk("reset width", 32'(width24), 32'd0);
    chk("reset period", 32'(period24), 32'd0);
    chk("reset ovf", 32'(ovf24), 32'd0);
    res_n = 1'b1;
    tick(5);

    // Basic measurement: 10 high, 15 low.
    do_arm24("basic");
    q24.push_back('{w: 24'd10, p: 24'd25, ovf: 1'b0});
    pulse(10, 15);
    pulse(10, 15);
    wait_v24("basic", 30);
    chk("basic busy after", 32'(busy24), 32'd0);

    // Armed while input already high: partial pulse ignored.
    sig = 1'b1;
    tick(5);
    do_arm24("prehigh");
    q24.push_back('{w: 24'd4, p: 24'd10, ovf: 1'b0});
    tick(3);
    sig = 1'b0;
    tick(5);
    pulse(4, 6);
    sig = 1'b1;
    tick(2);
    sig = 1'b0;
    wait_v24("prehigh", 20);

    // 4-bit counter: held high saturates everything.
    do_arm4("ovf_hi");
    q4.push_back('{w: 24'd15, p: 24'd15, ovf: 1'b1});
    sig = 1'b1;
    tick(20);
    wait_v4("ovf_hi", 20);
    sig = 1'b0;
    tick(5);

    // 4-bit counter: short high, long low saturates only the period.
    do_arm4("ovf_lo");
    q4.push_back('{w: 24'd3, p: 24'd15, ovf: 1'b1});
    pulse(3, 25);
    wait_v4("ovf_lo", 20);

    // 4-bit counter: rise lands exactly at the all-ones count, edge wins.
    do_arm4("ovf_edge");
    q4.push_back('{w: 24'd3, p: 24'd15, ovf: 1'b0});
    pulse(3, 12);
    sig = 1'b1;
    tick(3);
    sig = 1'b0;
    wait_v4("ovf_edge", 20);
    tick(3);

    // Re-arm during HIGH, then a clean 5/5 pulse.
    do_arm24("rearm0");
    q24.push_back('{w: 24'd5, p: 24'd10, ovf: 1'b0});
    sig = 1'b1;
    tick(6);
    do_arm24("rearm_high");
    tick(2);
    sig = 1'b0;
    tick(5);
    chk("rearm still busy", 32'(busy24), 32'd1);
    pulse(5, 5);
    sig = 1'b1;
    tick(2);
    sig = 1'b0;
    wait_v24("rearm", 20);

    // Re-arm in DONE clears the held result.
    do_arm24("rearm_done");
    chk("rearm_done width", 32'(width24), 32'd0);
    chk("rearm_done period", 32'(period24), 32'd0);

    // Minimum pulse: 1 high, 1 low.
    do_arm24("minpulse");
    q24.push_back('{w: 24'd1, p: 24'd2, ovf: 1'b0});
    repeat (4) pulse(1, 1);
    wait_v24("minpulse", 20);
    tick(3);

    // Reset asserted while in LOW.
    do_arm24("rst_low");
    pulse(4, 6);
    chk("rst_low busy before", 32'(busy24), 32'd1);
    #2 res_n = 1'b0;
    #1;
    chk("rst_low busy", 32'(busy24), 32'd0);
    chk("rst_low valid", 32'(valid24), 32'd0);
    chk("rst_low width", 32'(width24), 32'd0);
    chk("rst_low period", 32'(period24), 32'd0);
    chk("rst_low ovf", 32'(ovf24), 32'd0);
    tick(2);
    res_n = 1'b1;
    tick(5);
    pulse(3, 3);
    pulse(3, 3);
    chk("idle after reset busy", 32'(busy24), 32'd0);
    chk("idle after reset valid", 32'(valid24), 32'd0);

    // Input held high through reset release, armed at once.
    sig = 1'b1;
    tick(3);
    #2 res_n = 1'b0;
    tick(2);
    res_n = 1'b1;
    do_arm24("rst_high");
    q24.push_back('{w: 24'd3, p: 24'd7, ovf: 1'b0});
    tick(5);
    chk("rst_high no false rise busy", 32'(busy24), 32'd1);
    chk("rst_high no false rise valid", 32'(valid24), 32'd0);
    sig = 1'b0;
    tick(4);
    pulse(3, 4);
    sig = 1'b1;
    tick(2);
    sig = 1'b0;
    wait_v24("rst_high", 20);

    tick(3);
    chk("q24 drained", 32'(q24.size()), 32'd0);
    chk("q4 drained", 32'(q4.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
